// File: rtl/axis_frame_packer_if.sv
// AXI4-Stream bundle (data, valid, ready, user, last) shared by the packer's input and output sides.
// Latency: none, wires only.
// Backpressure: tready runs against the direction of tdata/tvalid/tuser/tlast.
// Ports: master drives tdata/tvalid/tuser/tlast and samples tready; slave is the mirror image.
interface axis_frame_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_frame_packer.sv
// Frame packer: tags a raw BGR pixel stream with SOF (tuser) and line/frame end (tlast) for an S2MM DMA.
// Latency: 1 cycle input to output; sustains 1 pixel/clk while m_axis.tready stays high.
// Backpressure: a 2-entry skid buffer absorbs a stall; s_axis.tready is registered and drops only when both entries are full.
// Ports: ACLK/ARESETn (async active-low); enable gates input acceptance; s_axis = pixel input
//        (tuser ignored, tlast checked only); m_axis = tagged output; o_intr = frame-done pulse;
//        o_err = sticky framing error.
module axis_frame_packer #(
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter bit LAST_PER_LINE = 1'b0,
    parameter int CNT_W         = 10
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        enable,
    axis_frame_packer_if.slave          s_axis,
    axis_frame_packer_if.master         m_axis,
    output logic                        o_intr,
    output logic                        o_err
);

    typedef struct packed {
        logic [31:0] dat;
        logic        user;
        logic        last;
        logic        fend;   // frame end, including an early resync end
    } pix_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       st_q, st_d;
    pix_t             out_q, out_d;
    pix_t             spr_q, spr_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             err_q, err_d;
    logic             intr_q, intr_d;

    logic in_xfer, out_xfer;
    logic last_col, frame_end, early_end;
    pix_t new_pix;

    // Upper byte of the input and the input tuser carry nothing for this block.
    logic unused_in;
    assign unused_in = ^{s_axis.tdata[31:24], s_axis.tuser};

    always_comb begin
        in_xfer   = s_axis.tvalid & rdy_q;
        out_xfer  = (st_q != ST_EMPTY) & m_axis.tready;
        last_col  = (col_q == CNT_W'(IMG_WIDTH - 1));
        frame_end = last_col & (row_q == CNT_W'(IMG_HEIGHT - 1));
        // Upstream claims end-of-frame before our counters agree: cut the frame here.
        early_end = s_axis.tlast & ~frame_end;

        new_pix.dat  = {8'h00, s_axis.tdata[23:0]};
        new_pix.user = (col_q == '0) && (row_q == '0);
        new_pix.last = frame_end | early_end | (LAST_PER_LINE & last_col);
        new_pix.fend = frame_end | early_end;

        st_d  = st_q;
        out_d = out_q;
        spr_d = spr_q;
        case (st_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    out_d = new_pix;
                    st_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: out_d = new_pix;
                    2'b10: begin
                        spr_d = new_pix;
                        st_d  = ST_TWO;
                    end
                    2'b01: st_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (out_xfer) begin
                    out_d = spr_q;
                    st_d  = ST_ONE;
                end
            end
            default: st_d = ST_EMPTY;
        endcase

        // Looking at the next state lets ready fall in the same cycle the spare fills.
        rdy_d = enable & (st_d != ST_TWO);

        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (frame_end | early_end) begin
                col_d = '0;
                row_d = '0;
            end else if (last_col) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        err_d  = err_q | (in_xfer & (early_end | (frame_end & ~s_axis.tlast)));
        intr_d = out_xfer & out_q.fend;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            st_q   <= ST_EMPTY;
            out_q  <= '0;
            spr_q  <= '0;
            rdy_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            err_q  <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            out_q  <= out_d;
            spr_q  <= spr_d;
            rdy_q  <= rdy_d;
            col_q  <= col_d;
            row_q  <= row_d;
            err_q  <= err_d;
            intr_q <= intr_d;
        end
    end

    assign s_axis.tready = rdy_q;
    assign m_axis.tvalid = (st_q != ST_EMPTY);
    assign m_axis.tdata  = out_q.dat;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;
    assign o_intr        = intr_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: two 4x2 instances (tlast per frame / per line) share one stimulus stream.
// Latency: expects output one cycle after input acceptance.
// Backpressure: downstream ready is driven by the bench, including a 1,0,0,1 stall pattern.
module tb_axis_frame_packer;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic enable;
    always #5 ACLK = ~ACLK;

    axis_frame_packer_if s_if0();
    axis_frame_packer_if s_if1();
    axis_frame_packer_if m_if0();
    axis_frame_packer_if m_if1();

    logic        s_vld, s_last, m_rdy;
    logic [31:0] s_dat;
    logic        intr0, err0, intr1, err1;

    assign s_if0.tvalid = s_vld;
    assign s_if0.tdata  = s_dat;
    assign s_if0.tlast  = s_last;
    assign s_if0.tuser  = 1'b0;
    assign s_if1.tvalid = s_vld;
    assign s_if1.tdata  = s_dat;
    assign s_if1.tlast  = s_last;
    assign s_if1.tuser  = 1'b0;
    assign m_if0.tready = m_rdy;
    assign m_if1.tready = m_rdy;

    axis_frame_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .LAST_PER_LINE(1'b0), .CNT_W(10)) dut0 (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable),
        .s_axis(s_if0.slave), .m_axis(m_if0.master), .o_intr(intr0), .o_err(err0));

    axis_frame_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .LAST_PER_LINE(1'b1), .CNT_W(10)) dut1 (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable),
        .s_axis(s_if1.slave), .m_axis(m_if1.master), .o_intr(intr1), .o_err(err1));

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
        logic        f;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic pend[2];
    logic stall_v[2];
    exp_t stall_e[2];
    int   first_in, first_out, last_out;
    bit   log_en, saw_drop, done;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One monitor step per DUT, at each falling edge; a transfer seen here completes at the next rising edge.
    task automatic mon_step(input int k, input logic v, input logic r, input logic [31:0] d,
                            input logic u, input logic l, input logic intr);
        exp_t e;
        bit   empty;
        if (!ARESETn) begin
            pend[k]    = 1'b0;
            stall_v[k] = 1'b0;
            return;
        end
        chk($sformatf("intr%0d", k), {31'd0, intr}, {31'd0, pend[k]});
        if (stall_v[k]) begin
            chk($sformatf("stall_vld%0d", k), {31'd0, v}, 32'd1);
            chk($sformatf("stall_dat%0d", k), d, stall_e[k].d);
            chk($sformatf("stall_tag%0d", k), {30'd0, u, l}, {30'd0, stall_e[k].u, stall_e[k].l});
        end
        pend[k] = 1'b0;
        if (v && r) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                total++;
                bad++;
                $display("FAIL unexpected_out%0d: got %h want nothing", k, d);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("data%0d", k), d, e.d);
                chk($sformatf("tuser%0d", k), {31'd0, u}, {31'd0, e.u});
                chk($sformatf("tlast%0d", k), {31'd0, l}, {31'd0, e.l});
                pend[k] = e.f;
                if (k == 0 && log_en) begin
                    if (first_out < 0) first_out = cyc + 1;
                    last_out = cyc + 1;
                end
            end
        end
        stall_v[k]   = v && !r;
        stall_e[k].d = d;
        stall_e[k].u = u;
        stall_e[k].l = l;
        stall_e[k].f = 1'b0;
    endtask

    always @(negedge ACLK) begin
        mon_step(0, m_if0.tvalid, m_if0.tready, m_if0.tdata, m_if0.tuser, m_if0.tlast, intr0);
        mon_step(1, m_if1.tvalid, m_if1.tready, m_if1.tdata, m_if1.tuser, m_if1.tlast, intr1);
    end

    // Present one pixel and hold it until accepted; expected tags are supplied by the caller.
    task automatic send(input logic [31:0] d, input logic tl, input logic eu,
                        input logic el0, input logic el1, input logic ef);
        exp_t e;
        int   n = 0;
        s_dat  = d;
        s_last = tl;
        s_vld  = 1'b1;
        forever begin
            @(negedge ACLK);
            if (s_if0.tready && s_if1.tready) break;
            saw_drop = 1'b1;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no ready want ready for %h", d);
                return;
            end
        end
        e.d = d & 32'h00FF_FFFF;
        e.u = eu;
        e.f = ef;
        e.l = el0;
        q0.push_back(e);
        e.l = el1;
        q1.push_back(e);
        @(posedge ACLK);
        #1;
        if (log_en && first_in < 0) first_in = cyc;
    endtask

    task automatic idle();
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    // Well-formed 4x2 frame: SOF on pixel 1, line end on pixel 4, frame end on pixel 8.
    task automatic frame(input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            send(base + 32'(i + 1), i == 7, i == 0, i == 7, (i == 3) || (i == 7), i == 7);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        repeat (2) @(posedge ACLK);
        #1;
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        enable  = 1'b1;
        m_rdy   = 1'b1;
        s_vld   = 1'b0;
        s_dat   = '0;
        s_last  = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        first_in = -1; first_out = -1; last_out = -1;
        log_en = 1'b0; saw_drop = 1'b0; done = 1'b0;

        // Reset state
        #12;
        chk("rst_vld0", {31'd0, m_if0.tvalid}, 32'd0);
        chk("rst_dat0", m_if0.tdata, 32'd0);
        chk("rst_usr0", {31'd0, m_if0.tuser}, 32'd0);
        chk("rst_lst0", {31'd0, m_if0.tlast}, 32'd0);
        chk("rst_int0", {31'd0, intr0}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_rdy0", {31'd0, s_if0.tready}, 32'd0);
        chk("rst_vld1", {31'd0, m_if1.tvalid}, 32'd0);
        chk("rst_rdy1", {31'd0, s_if1.tready}, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("rdy_before_edge", {31'd0, s_if0.tready}, 32'd0);
        @(posedge ACLK);
        #1;
        chk("rdy_after_release", {31'd0, s_if0.tready}, 32'd1);

        // Back-to-back frame, upper byte set to FF, correct upstream tlast
        log_en = 1'b1;
        frame(32'hFF00_0000);
        idle();
        drain();
        log_en = 1'b0;
        chk("latency", 32'(first_out - first_in), 32'd1);
        chk("no_bubbles", 32'(last_out - first_out), 32'd7);
        chk("err0_clean", {31'd0, err0}, 32'd0);
        chk("err1_clean", {31'd0, err1}, 32'd0);

        // Downstream stall pattern 1,0,0,1 with input held valid
        saw_drop = 1'b0;
        done     = 1'b0;
        fork
            begin
                frame(32'h1234_0000);
                done = 1'b1;
            end
            begin
                int ph = 0;
                while (!done) begin
                    m_rdy = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                    @(posedge ACLK);
                    #1;
                end
            end
        join
        m_rdy = 1'b1;
        idle();
        drain();
        chk("ready_dropped", {31'd0, saw_drop}, 32'd1);

        // enable low for 5 cycles after pixel 2; tagging resumes at col 2
        send(32'h0000_0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK);
            #1;
            chk($sformatf("dis_rdy0_%0d", i), {31'd0, s_if0.tready}, 32'd0);
            chk($sformatf("dis_rdy1_%0d", i), {31'd0, s_if1.tready}, 32'd0);
        end
        chk("dis_drained", 32'(q0.size() + q1.size()), 32'd0);
        enable = 1'b1;
        for (int i = 2; i < 8; i++)
            send(32'h0000_0100 + 32'(i + 1), i == 7, 1'b0, i == 7, (i == 3) || (i == 7), i == 7);
        idle();
        drain();

        // Early upstream tlast on pixel 3, then a fresh frame starting with SOF
        send(32'h0000_0201, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0203, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        frame(32'h0000_0300);
        idle();
        drain();
        chk("err0_early", {31'd0, err0}, 32'd1);
        chk("err1_early", {31'd0, err1}, 32'd1);

        // Fill both entries, then reset asynchronously in mid-cycle
        m_rdy = 1'b0;
        send(32'h0000_0401, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0402, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("two_rdy0", {31'd0, s_if0.tready}, 32'd0);
        chk("two_rdy1", {31'd0, s_if1.tready}, 32'd0);
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        #1;
        chk("arst_vld0", {31'd0, m_if0.tvalid}, 32'd0);
        chk("arst_vld1", {31'd0, m_if1.tvalid}, 32'd0);
        chk("arst_err0", {31'd0, err0}, 32'd0);
        q0.delete();
        q1.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        m_rdy   = 1'b1;
        @(posedge ACLK);
        #1;
        chk("arst_rdy_rise", {31'd0, s_if0.tready}, 32'd1);
        frame(32'h0000_0500);
        idle();
        drain();

        chk("final_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_packer.md
Name: axis_frame_packer

Overview:
- Receive-side companion to DCP_HazeRemoval. Consumes its pixel-only AXI4-Stream output (BGR in TDATA[23:0]) and re-emits a DMA-ready AXI4-Stream.
- Adds TUSER start-of-frame, TLAST (end-of-line or end-of-frame), and full backpressure through a 2-entry skid buffer.
- Raises a frame-done interrupt and a sticky framing-error flag.
- Sits between the haze-removal core and the S2MM DMA.

Parameters:
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- LAST_PER_LINE, 0, 1 = TLAST on every line end; 0 = TLAST on frame end only
- CNT_W, 10, width of column and row counters; must satisfy 2^CNT_W >= max(IMG_WIDTH, IMG_HEIGHT)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- enable  in  1  1 = accept input; 0 = S_AXIS_TREADY low, buffered data still drains
- S_AXIS_TDATA  in  32  pixel, [7:0] B, [15:8] G, [23:16] R, [31:24] ignored
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TLAST  in  1  upstream end-of-frame marker; optional, checked only
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA  out  32  pixel, [31:24] forced to 0
- M_AXIS_TUSER  out  1  1 on first pixel of frame
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TLAST  out  1  line or frame end, per LAST_PER_LINE
- M_AXIS_TREADY  in  1  downstream ready
- o_intr  out  1  one-cycle pulse when last pixel of frame is accepted downstream
- o_err  out  1  sticky framing error; cleared only by reset

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - outputs: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TUSER=0, M_AXIS_TLAST=0, o_intr=0, o_err=0, S_AXIS_TREADY=0.
  - internal: col=row=0, skid buffer EMPTY.
  - S_AXIS_TREADY rises the first cycle after reset release if enable=1.
- Handshake: input transfer = S_AXIS_TVALID & S_AXIS_TREADY; output transfer = M_AXIS_TVALID & M_AXIS_TREADY.
  - M_AXIS_TDATA, M_AXIS_TUSER and M_AXIS_TLAST hold stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
- Skid buffer FSM (output register plus spare register):
  - EMPTY -> ONE on input transfer.
  - ONE -> TWO on input transfer with no output transfer.
  - ONE -> EMPTY on output transfer with no input transfer.
  - ONE stays ONE on simultaneous input and output transfer.
  - TWO -> ONE on output transfer. No input is accepted in TWO.
  - S_AXIS_TREADY = enable & (state != TWO), registered.
  - Latency input->output is 1 cycle. Throughput is 1 pixel/clk with M_AXIS_TREADY held high.
- Tagging (applied on input transfer, stored with the pixel):
  - TUSER = (col==0 && row==0).
  - Frame end = (col==IMG_WIDTH-1 && row==IMG_HEIGHT-1).
  - TLAST = frame end, or (LAST_PER_LINE && col==IMG_WIDTH-1).
- Counters: col increments per input transfer and wraps to 0 at IMG_WIDTH-1. row increments on col wrap and wraps to 0 at frame end.
- Upstream TLAST check, on input transfer:
  - TLAST=1 before frame end: o_err <= 1; the pixel is tagged TLAST=1; col and row reset to 0 (resync to next frame).
  - TLAST=0 at frame end: o_err <= 1; tagging proceeds normally.
  - TLAST=1 at frame end: no error.
- o_intr: high exactly one cycle, the cycle after the output transfer of a pixel tagged as frame end (including an early-resync end).
- enable deassert mid-frame: counters hold, buffered pixels drain, resume at the same col/row on reassert.
- Reset mid-frame: all buffered pixels are discarded; the next input pixel is tagged TUSER=1.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, LAST_PER_LINE=0, M_AXIS_TREADY=1, 8 back-to-back pixels 0x00000001..0x00000008 (with TDATA[31:24]=0xFF) -> outputs 1 cycle later, [31:24]=0, TUSER on pixel 1 only, TLAST on pixel 8 only, o_intr one pulse, o_err=0, no bubbles.
- Same configuration, LAST_PER_LINE=1 -> TLAST on pixels 4 and 8; TUSER on pixel 1; one o_intr.
- M_AXIS_TREADY toggling 1,0,0,1 while TVALID is held -> S_AXIS_TREADY drops after two pixels are buffered; no pixel lost or duplicated; output data is stable during stall; order 1..8 is preserved.
- Input TLAST asserted on pixel 3 of a 4x2 frame -> pixel 3 out with TLAST=1, o_err=1, o_intr pulses; next pixel tagged TUSER=1.
- enable=0 for 5 cycles mid-line (after pixel 2) -> S_AXIS_TREADY=0; pending pixels drain; pixel 3 resumes with col=2 tagging and TLAST lands on pixel 8.
- ARESETn pulsed low while in TWO -> M_AXIS_TVALID=0 immediately (asynchronous); next accepted pixel has TUSER=1.
